search_mon: RTL and testbench
=============================

Name: search_mon

Overview:
- Synthesizable in-system monitor for the rule-search RAM array.
- Sits beside the search engine and passively observes its request/response buses.
- Pairs every accepted search with its hit/miss response in order, measures latency, and keeps saturating statistics.
- Raises sticky protocol-error flags (orphan response, overflow, not-ready issue, timeout, bad table index). Usable in the bench and as on-chip debug.

Parameters:
- C_NUM_TABLE, 4: number of block RAMs; legal values 1, 2, 4, 8, 16.
- C_RULE_WIDTH, 24: key/rule width.
- C_MEM_DATA_WIDTH, 56: RAM word width; hit data width is C_MEM_DATA_WIDTH-C_RULE_WIDTH.
- C_MEM_ADDR_WIDTH, 8: RAM address width.
- C_MAX_PEND, 8: depth of the outstanding-search FIFO; power of 2, at least 2.
- C_TIMEOUT, 64: maximum cycles from issue to response; must be less than 2**C_LAT_WIDTH.
- C_LAT_WIDTH, 16: width of the timestamp and latency values.
- C_CNT_WIDTH, 32: width of the statistics counters.
- C_STOP_ON_ERR, 0: 1 means freeze all statistics on the first error until clear.

Ports:
- clk_i  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous clear of FIFO, counters, error flags and FSM
- search_i  in  1  search strobe
- key_i  in  C_RULE_WIDTH  searched key
- ready_i  in  C_NUM_TABLE  per-table ready
- busy_i  in  C_NUM_TABLE  per-table busy
- hit_vd_i  in  1  response strobe
- hit_i  in  1  1 = found
- hit_tab_i  in  4  table index of the hit
- hit_addr_i  in  C_MEM_ADDR_WIDTH  address of the hit
- hit_data_i  in  C_MEM_DATA_WIDTH-C_RULE_WIDTH  data of the hit
- resp_vd_o  out  1  paired-response strobe
- resp_key_o  out  C_RULE_WIDTH  key of the paired search
- resp_hit_o  out  1  registered hit_i
- resp_lat_o  out  C_LAT_WIDTH  issue-to-response latency in cycles
- search_cnt_o, hit_cnt_o, miss_cnt_o  out  C_CNT_WIDTH  saturating counters
- lat_max_o  out  C_LAT_WIDTH  maximum latency seen
- pend_o  out  $clog2(C_MAX_PEND)+1  current FIFO occupancy
- err_o  out  5  sticky flags {tab, timeout, notready, overflow, orphan} (bit 4 down to 0)
- state_o  out  2  FSM state

Behaviour:
- Reset (rstn=0) or clear_i=1: every output is 0, FIFO empty, timestamp counter 0, FSM IDLE. clear_i takes priority over all other same-cycle events.
- Timestamp counter: free-running, C_LAT_WIDTH bits, wraps around.
- Latency: (now - stored timestamp) mod 2**C_LAT_WIDTH. This is correct across wrap because C_TIMEOUT < 2**C_LAT_WIDTH.
- Issue, on search_i=1:
  - search_cnt increments.
  - If any busy_i=1 or any ready_i=0, set err notready; the entry is still pushed.
  - If the FIFO is full and no pop happens in the same cycle, set err overflow and drop the entry.
  - Otherwise push {key_i, timestamp}.
- Response, on hit_vd_i=1:
  - If the FIFO is empty, set err orphan; no resp_vd_o is produced.
  - Otherwise pop the head. One cycle later drive resp_vd_o=1 with the head key, registered hit_i, and the latency.
  - hit_i=1 increments hit_cnt; otherwise miss_cnt increments.
  - lat_max updates when the new latency exceeds it.
  - hit_i=1 with hit_tab_i >= C_NUM_TABLE sets err tab.
- Simultaneous push and pop:
  - The pop is evaluated first, so a full FIFO accepts the push.
  - With an empty FIFO, the response is an orphan and the new search is still pushed.
- Timeout: when FIFO is non-empty and the head age reaches C_TIMEOUT, set err timeout and pop the head with no resp_vd_o.
  - If a hit_vd_i arrives in the same cycle, the response pop wins and no timeout is flagged.
- Counters saturate at all-ones. pend_o is registered FIFO occupancy.
- FSM (state_o encoding 0/1/2):
  - IDLE (0): FIFO empty. Goes to WAIT on push.
  - WAIT (1): FIFO non-empty. Goes to IDLE when the FIFO becomes empty.
  - HALT (2): entered from any state on a new error when C_STOP_ON_ERR=1.
- In HALT: counters, lat_max, FIFO and resp_vd_o are frozen; err_o keeps accumulating. Only clear_i or reset leaves HALT, to IDLE.
- Error flags are sticky until clear_i or reset.

Decomposition:
- Package search_mon_pkg holds:
  - typedef state_t {IDLE, WAIT, HALT};
  - error bit index constants ERR_ORPHAN=0 .. ERR_TAB=4;
  - a function sat_inc for saturating increment.
- Sub-module search_mon_fifo: synchronous FIFO of width C_RULE_WIDTH+C_LAT_WIDTH and depth C_MAX_PEND.
  - Outputs: full, empty, count.
  - Supports push and pop in the same cycle when full.

Test Plan:
- Three searches at cycles 10, 11, 12, all ready, no busy; responses at cycles 15, 17, 18 with hit=1,0,1 -> resp_vd_o in cycles 16, 18, 19; keys in issue order; latencies 5, 6, 6; hit_cnt=2, miss_cnt=1; lat_max=6; err_o=0.
- hit_vd_i with FIFO empty -> err_o=5'b00001, no resp_vd_o. clear_i -> err_o=0, counters 0, state_o=IDLE.
- Fill 8 pending (C_MAX_PEND=8), then a 9th search -> err overflow, pend_o stays 8. Repeat with a simultaneous hit_vd_i -> no error, pend_o=8.
- Single search with no response -> err timeout exactly 64 cycles after issue, pend_o returns to 0, no resp_vd_o.
- busy_i=4'b0010 during a search -> err notready, entry still paired, resp_vd_o produced. Hit with hit_tab_i=5 -> err tab.
- C_STOP_ON_ERR=1: orphan response then 4 searches -> state_o=HALT, search_cnt frozen, err_o=1. After clear_i, normal pairing resumes. Also run the first scenario with the timestamp starting near 16'hFFFE -> latencies still 5, 6, 6.

Source files
------------

// File: rtl/search_mon_pkg.sv
// Shared types, error-bit indices and helpers for the rule-search monitor.
package search_mon_pkg;

    // Monitor FSM state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    // Bit positions inside the sticky error vector.
    localparam int ERR_ORPHAN   = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_NOTREADY = 2;
    localparam int ERR_TIMEOUT  = 3;
    localparam int ERR_TAB      = 4;
    localparam int ERR_W        = 5;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/search_mon_fifo.sv
// Outstanding-search FIFO: holds {key, issue timestamp} in issue order.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module search_mon_fifo #(
    parameter int C_WIDTH = 40,
    parameter int C_DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [C_WIDTH-1:0]       wr_data_i,
    output logic [C_WIDTH-1:0]       rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(C_DEPTH):0] count_o
);

    localparam int AW = $clog2(C_DEPTH);
    localparam int CW = AW + 1;

    logic [C_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               do_push;
    logic               do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(C_DEPTH));
    assign do_pop    = pop_i & ~empty_o;
    assign do_push   = push_i & (~full_o | do_pop);
    assign rd_data_o = mem[rd_ptr_q];
    assign count_o   = count_q;

    // Storage write.
    // NOTE: the data array has no reset; occupancy is tracked by the pointers and
    // count, so stale words are never observed and the array can map to plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap because the depth is a power of 2.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/search_mon.sv
// Passive monitor for the rule-search RAM array: pairs searches with responses
// in order, measures latency, keeps saturating statistics and sticky error flags.
module search_mon
    import search_mon_pkg::*;
#(
    parameter int C_NUM_TABLE      = 4,
    parameter int C_RULE_WIDTH     = 24,
    parameter int C_MEM_DATA_WIDTH = 56,
    parameter int C_MEM_ADDR_WIDTH = 8,
    parameter int C_MAX_PEND       = 8,
    parameter int C_TIMEOUT        = 64,
    parameter int C_LAT_WIDTH      = 16,
    parameter int C_CNT_WIDTH      = 32,
    parameter int C_STOP_ON_ERR    = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rstn,
    input  logic                                   clear_i,
    input  logic                                   search_i,
    input  logic [C_RULE_WIDTH-1:0]                key_i,
    input  logic [C_NUM_TABLE-1:0]                 ready_i,
    input  logic [C_NUM_TABLE-1:0]                 busy_i,
    input  logic                                   hit_vd_i,
    input  logic                                   hit_i,
    input  logic [3:0]                             hit_tab_i,
    input  logic [C_MEM_ADDR_WIDTH-1:0]            hit_addr_i,
    input  logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] hit_data_i,
    output logic                                   resp_vd_o,
    output logic [C_RULE_WIDTH-1:0]                resp_key_o,
    output logic                                   resp_hit_o,
    output logic [C_LAT_WIDTH-1:0]                 resp_lat_o,
    output logic [C_CNT_WIDTH-1:0]                 search_cnt_o,
    output logic [C_CNT_WIDTH-1:0]                 hit_cnt_o,
    output logic [C_CNT_WIDTH-1:0]                 miss_cnt_o,
    output logic [C_LAT_WIDTH-1:0]                 lat_max_o,
    output logic [$clog2(C_MAX_PEND):0]            pend_o,
    output logic [4:0]                             err_o,
    output logic [1:0]                             state_o
);

    localparam int PW = $clog2(C_MAX_PEND) + 1;
    localparam int FW = C_RULE_WIDTH + C_LAT_WIDTH;
    localparam logic [C_LAT_WIDTH-1:0] TMO = C_LAT_WIDTH'(C_TIMEOUT);

    state_t                  state_q, state_d;
    logic [C_LAT_WIDTH-1:0]  ts_q;
    logic [C_LAT_WIDTH-1:0]  lat_max_q;
    logic [C_CNT_WIDTH-1:0]  search_cnt_q, hit_cnt_q, miss_cnt_q;
    logic [ERR_W-1:0]        err_q, err_set;
    logic                    resp_vd_q, resp_hit_q;
    logic [C_RULE_WIDTH-1:0] resp_key_q;
    logic [C_LAT_WIDTH-1:0]  resp_lat_q;

    logic                    fifo_full, fifo_empty;
    logic [PW-1:0]           fifo_count, count_next;
    logic [FW-1:0]           head;
    logic [C_RULE_WIDTH-1:0] head_key;
    logic [C_LAT_WIDTH-1:0]  head_ts, age;

    logic                    halt;
    logic                    resp_pop, tmo_pop, pop_en, resp_pop_en, push_en;

    // Hit address/data are observed but not needed for pairing.
    logic unused_hit_fields;
    assign unused_hit_fields = ^{hit_addr_i, hit_data_i};

    assign {head_key, head_ts} = head;
    assign age  = ts_q - head_ts;   // modular difference, valid across wrap
    assign halt = (state_q == HALT);

    search_mon_fifo #(
        .C_WIDTH (FW),
        .C_DEPTH (C_MAX_PEND)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .clear_i   (clear_i),
        .push_i    (push_en),
        .pop_i     (pop_en),
        .wr_data_i ({key_i, ts_q}),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Issue/response/timeout decisions and error events for this cycle.
    // NOTE: every signal gets a default at the top of the block, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        err_set     = '0;
        resp_pop    = hit_vd_i & ~fifo_empty;
        tmo_pop     = ~fifo_empty & ~hit_vd_i & (age >= TMO);
        resp_pop_en = resp_pop & ~halt;
        pop_en      = (resp_pop | tmo_pop) & ~halt;
        push_en     = search_i & ~halt & (~fifo_full | pop_en);
        count_next  = fifo_count + PW'(push_en) - PW'(pop_en);

        err_set[ERR_ORPHAN]   = hit_vd_i & fifo_empty;
        err_set[ERR_OVERFLOW] = search_i & fifo_full & ~pop_en;
        err_set[ERR_NOTREADY] = search_i & ((|busy_i) | ~(&ready_i));
        err_set[ERR_TIMEOUT]  = tmo_pop;
        err_set[ERR_TAB]      = hit_vd_i & hit_i & ({1'b0, hit_tab_i} >= 5'(C_NUM_TABLE));
    end

    // FSM next state: track FIFO occupancy, divert to HALT on any error when enabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push_en) state_d = WAIT;
            WAIT:    if (count_next == '0) state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if ((C_STOP_ON_ERR != 0) && (|err_set)) begin
            state_d = HALT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Free-running timestamp and sticky error flags (flags keep accumulating in HALT).
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            ts_q  <= '0;
            err_q <= '0;
        end else if (clear_i) begin
            ts_q  <= '0;
            err_q <= '0;
        end else begin
            ts_q  <= ts_q + C_LAT_WIDTH'(1);
            err_q <= err_q | err_set;
        end
    end

    // Statistics counters and maximum latency; frozen while halted.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            search_cnt_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            lat_max_q    <= '0;
        end else if (clear_i) begin
            search_cnt_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            lat_max_q    <= '0;
        end else if (!halt) begin
            if (search_i) begin
                search_cnt_q <= C_CNT_WIDTH'(sat_inc(64'(search_cnt_q), C_CNT_WIDTH));
            end
            if (resp_pop_en) begin
                if (hit_i) hit_cnt_q  <= C_CNT_WIDTH'(sat_inc(64'(hit_cnt_q), C_CNT_WIDTH));
                else       miss_cnt_q <= C_CNT_WIDTH'(sat_inc(64'(miss_cnt_q), C_CNT_WIDTH));
                if (age > lat_max_q) lat_max_q <= age;
            end
        end
    end

    // Paired-response output register, one cycle after the response is accepted.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            resp_vd_q  <= 1'b0;
            resp_key_q <= '0;
            resp_hit_q <= 1'b0;
            resp_lat_q <= '0;
        end else if (clear_i) begin
            resp_vd_q  <= 1'b0;
            resp_key_q <= '0;
            resp_hit_q <= 1'b0;
            resp_lat_q <= '0;
        end else begin
            resp_vd_q <= resp_pop_en;
            if (resp_pop_en) begin
                resp_key_q <= head_key;
                resp_hit_q <= hit_i;
                resp_lat_q <= age;
            end
        end
    end

    assign resp_vd_o    = resp_vd_q;
    assign resp_key_o   = resp_key_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_lat_o   = resp_lat_q;
    assign search_cnt_o = search_cnt_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;
    assign lat_max_o    = lat_max_q;
    assign pend_o       = fifo_count;
    assign err_o        = err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_search_mon.sv
// Directed bench for search_mon: two instances share stimulus, one with
// stop-on-error enabled. Outputs are sampled 1 ns after the rising edge.
module tb_search_mon;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic        search;
    logic [23:0] key;
    logic [3:0]  ready;
    logic [3:0]  busy;
    logic        hit_vd;
    logic        hit;
    logic [3:0]  hit_tab;
    logic [7:0]  hit_addr;
    logic [31:0] hit_data;

    logic        d0_vd, d1_vd, d0_rhit, d1_rhit;
    logic [23:0] d0_key, d1_key;
    logic [15:0] d0_lat, d1_lat, d0_lmax, d1_lmax;
    logic [31:0] d0_scnt, d1_scnt, d0_hcnt, d1_hcnt, d0_mcnt, d1_mcnt;
    logic [3:0]  d0_pend, d1_pend;
    logic [4:0]  d0_err, d1_err;
    logic [1:0]  d0_state, d1_state;

    // Snapshot of the selected instance's outputs.
    logic        o_vd, o_rhit;
    logic [23:0] o_key;
    logic [15:0] o_lat, o_lmax;
    logic [31:0] o_scnt, o_hcnt, o_mcnt;
    logic [3:0]  o_pend;
    logic [4:0]  o_err;
    logic [1:0]  o_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    search_mon #(.C_STOP_ON_ERR(0)) u_dut0 (
        .clk_i(clk), .rstn(rstn), .clear_i(clear), .search_i(search), .key_i(key),
        .ready_i(ready), .busy_i(busy), .hit_vd_i(hit_vd), .hit_i(hit), .hit_tab_i(hit_tab),
        .hit_addr_i(hit_addr), .hit_data_i(hit_data),
        .resp_vd_o(d0_vd), .resp_key_o(d0_key), .resp_hit_o(d0_rhit), .resp_lat_o(d0_lat),
        .search_cnt_o(d0_scnt), .hit_cnt_o(d0_hcnt), .miss_cnt_o(d0_mcnt),
        .lat_max_o(d0_lmax), .pend_o(d0_pend), .err_o(d0_err), .state_o(d0_state)
    );

    search_mon #(.C_STOP_ON_ERR(1)) u_dut1 (
        .clk_i(clk), .rstn(rstn), .clear_i(clear), .search_i(search), .key_i(key),
        .ready_i(ready), .busy_i(busy), .hit_vd_i(hit_vd), .hit_i(hit), .hit_tab_i(hit_tab),
        .hit_addr_i(hit_addr), .hit_data_i(hit_data),
        .resp_vd_o(d1_vd), .resp_key_o(d1_key), .resp_hit_o(d1_rhit), .resp_lat_o(d1_lat),
        .search_cnt_o(d1_scnt), .hit_cnt_o(d1_hcnt), .miss_cnt_o(d1_mcnt),
        .lat_max_o(d1_lmax), .pend_o(d1_pend), .err_o(d1_err), .state_o(d1_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap(input bit sel);
        o_vd    = sel ? d1_vd    : d0_vd;
        o_rhit  = sel ? d1_rhit  : d0_rhit;
        o_key   = sel ? d1_key   : d0_key;
        o_lat   = sel ? d1_lat   : d0_lat;
        o_lmax  = sel ? d1_lmax  : d0_lmax;
        o_scnt  = sel ? d1_scnt  : d0_scnt;
        o_hcnt  = sel ? d1_hcnt  : d0_hcnt;
        o_mcnt  = sel ? d1_mcnt  : d0_mcnt;
        o_pend  = sel ? d1_pend  : d0_pend;
        o_err   = sel ? d1_err   : d0_err;
        o_state = sel ? d1_state : d0_state;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clear   = 1'b0;
        search  = 1'b0;
        key     = '0;
        ready   = 4'hF;
        busy    = 4'h0;
        hit_vd  = 1'b0;
        hit     = 1'b0;
        hit_tab = 4'h0;
    endtask

    task automatic do_clear();
        set_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Searches in cycles 0,1,2; responses (hit,miss,hit) in cycles 5,7,8.
    task automatic run_pairing(input bit sel, input bit clr);
        logic [23:0] keys [3];
        logic [15:0] lats [3];
        bit          hits [3];
        int          ri;
        bit          exp_vd;
        keys[0] = 24'hA00001; keys[1] = 24'hA00002; keys[2] = 24'hA00003;
        lats[0] = 16'd5;      lats[1] = 16'd6;      lats[2] = 16'd6;
        hits[0] = 1'b1;       hits[1] = 1'b0;       hits[2] = 1'b1;
        ri = 0;
        if (clr) do_clear();
        for (int c = 0; c < 9; c++) begin
            set_idle();
            if (c <= 2) begin
                search = 1'b1;
                key    = keys[c];
            end
            exp_vd = (c == 5) || (c == 7) || (c == 8);
            hit_vd = exp_vd;
            hit    = exp_vd && (c != 7);
            tick();
            snap(sel);
            check($sformatf("pair_vd_c%0d", c), 64'(o_vd), 64'(exp_vd));
            if (c == 2) check("pair_pend3", 64'(o_pend), 64'd3);
            if (c == 2) check("pair_state_wait", 64'(o_state), 64'd1);
            if (exp_vd) begin
                check($sformatf("pair_key%0d", ri), 64'(o_key), 64'(keys[ri]));
                check($sformatf("pair_lat%0d", ri), 64'(o_lat), 64'(lats[ri]));
                check($sformatf("pair_hit%0d", ri), 64'(o_rhit), 64'(hits[ri]));
                ri++;
            end
        end
        set_idle();
        check("pair_search_cnt", 64'(o_scnt), 64'd3);
        check("pair_hit_cnt", 64'(o_hcnt), 64'd2);
        check("pair_miss_cnt", 64'(o_mcnt), 64'd1);
        check("pair_lat_max", 64'(o_lmax), 64'd6);
        check("pair_err", 64'(o_err), 64'd0);
        check("pair_pend0", 64'(o_pend), 64'd0);
        check("pair_state_idle", 64'(o_state), 64'd0);
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) begin
            set_idle();
            search = 1'b1;
            key    = 24'h000100 + 24'(i);
            tick();
        end
        set_idle();
    endtask

    initial begin
        bit saw_vd;
        set_idle();
        hit_addr = 8'h3C;
        hit_data = 32'hDEADBEEF;
        rstn     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        snap(0);
        check("rst_vd", 64'(o_vd), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_pend", 64'(o_pend), 64'd0);
        check("rst_state", 64'(o_state), 64'd0);
        check("rst_search_cnt", 64'(o_scnt), 64'd0);
        check("rst_lat_max", 64'(o_lmax), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Basic in-order pairing.
        run_pairing(0, 1);

        // Orphan response, then clear.
        set_idle();
        hit_vd = 1'b1;
        hit    = 1'b1;
        tick();
        set_idle();
        snap(0);
        check("orphan_err", 64'(o_err), 64'b00001);
        check("orphan_no_vd", 64'(o_vd), 64'd0);
        do_clear();
        snap(0);
        check("clr_err", 64'(o_err), 64'd0);
        check("clr_search_cnt", 64'(o_scnt), 64'd0);
        check("clr_hit_cnt", 64'(o_hcnt), 64'd0);
        check("clr_state", 64'(o_state), 64'd0);

        // Overflow on the ninth search.
        fill8();
        snap(0);
        check("full_pend", 64'(o_pend), 64'd8);
        check("full_err", 64'(o_err), 64'd0);
        search = 1'b1;
        key    = 24'h0001FF;
        tick();
        set_idle();
        snap(0);
        check("ovf_err", 64'(o_err), 64'b00010);
        check("ovf_pend", 64'(o_pend), 64'd8);

        // Full FIFO with simultaneous response: pop first, push accepted.
        do_clear();
        fill8();
        search = 1'b1;
        key    = 24'h0002AA;
        hit_vd = 1'b1;
        hit    = 1'b1;
        tick();
        set_idle();
        snap(0);
        check("pushpop_err", 64'(o_err), 64'd0);
        check("pushpop_pend", 64'(o_pend), 64'd8);
        check("pushpop_vd", 64'(o_vd), 64'd1);
        check("pushpop_key", 64'(o_key), 64'h000100);

        // Timeout exactly C_TIMEOUT cycles after issue.
        do_clear();
        search = 1'b1;
        key    = 24'h000777;
        tick();
        set_idle();
        saw_vd = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (d0_vd) saw_vd = 1'b1;
        end
        snap(0);
        check("tmo_early_err", 64'(o_err), 64'd0);
        check("tmo_early_pend", 64'(o_pend), 64'd1);
        tick();
        if (d0_vd) saw_vd = 1'b1;
        snap(0);
        check("tmo_err", 64'(o_err), 64'b01000);
        check("tmo_pend", 64'(o_pend), 64'd0);
        check("tmo_state", 64'(o_state), 64'd0);
        check("tmo_no_vd", 64'(saw_vd), 64'd0);

        // Not-ready issue still pairs; out-of-range hit table index.
        do_clear();
        search = 1'b1;
        key    = 24'h0055AA;
        busy   = 4'b0010;
        tick();
        set_idle();
        snap(0);
        check("nr_err", 64'(o_err), 64'b00100);
        check("nr_pend", 64'(o_pend), 64'd1);
        hit_vd  = 1'b1;
        hit     = 1'b1;
        hit_tab = 4'd5;
        tick();
        set_idle();
        snap(0);
        check("nr_vd", 64'(o_vd), 64'd1);
        check("nr_key", 64'(o_key), 64'h0055AA);
        check("tab_err", 64'(o_err), 64'b10100);
        check("tab_hit_cnt", 64'(o_hcnt), 64'd1);

        // Stop-on-error instance halts on an orphan and freezes statistics.
        do_clear();
        hit_vd = 1'b1;
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            search = 1'b1;
            key    = 24'h000900 + 24'(i);
            tick();
        end
        set_idle();
        snap(1);
        check("halt_state", 64'(o_state), 64'd2);
        check("halt_search_cnt", 64'(o_scnt), 64'd0);
        check("halt_err", 64'(o_err), 64'b00001);
        check("halt_pend", 64'(o_pend), 64'd0);
        snap(0);
        check("nohalt_search_cnt", 64'(o_scnt), 64'd4);
        run_pairing(1, 1);

        // Pairing across timestamp wrap: first search issued at timestamp 16'hFFFC.
        do_clear();
        for (int i = 0; i < 16'hFFFC; i++) tick();
        run_pairing(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
